latch_debounce_sync: RTL

//   Downstream consumer of the D latch output q. Synchronises the asynchronous level into the clk domain,

---
 rtl/latch_debounce_sync.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/latch_debounce_sync.sv
// latch_debounce_sync: synchronise an async level, debounce it, emit clean
// level with rise/fall pulses, busy while qualifying, saturating glitch count.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-high
//   q_in       in   asynchronous level from the D latch q
//   q_clean    out  debounced, registered level
//   rise       out  1-cycle pulse on q_clean 0->1
//   fall       out  1-cycle pulse on q_clean 1->0
//   busy       out  high while a candidate transition is being qualified
//   glitch_cnt out  aborted transitions, saturating at all-ones
module latch_debounce_sync #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int GCNT_W          = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              q_in,
   output logic              q_clean,
   output logic              rise,
   output logic              fall,
   output logic              busy,
   output logic [GCNT_W-1:0] glitch_cnt
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_LOW,
      W_HIGH,
      S_HIGH,
      W_LOW
   } state_t;

   logic [SYNC_STAGES-1:0] sync;
   logic                   sync_q;
   state_t                 state, state_n;
   logic [CW-1:0]          cnt, cnt_n;
   logic                   q_clean_n;
   logic                   rise_n;
   logic                   fall_n;
   logic                   gl_inc;

   assign sync_q = sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], q_in};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_LOW;
         cnt        <= '0;
         q_clean    <= 1'b0;
         rise       <= 1'b0;
         fall       <= 1'b0;
         busy       <= 1'b0;
         glitch_cnt <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         q_clean <= q_clean_n;
         rise    <= rise_n;
         fall    <= fall_n;
         busy    <= (state_n == W_HIGH) || (state_n == W_LOW);
         // hold at all-ones rather than wrap
         if (gl_inc && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      q_clean_n = q_clean;
      rise_n    = 1'b0;
      fall_n    = 1'b0;
      gl_inc    = 1'b0;
      unique case (state)
         S_LOW: begin
            if (sync_q) begin
               // single-sample debounce accepts straight away
               if (DEBOUNCE_CYCLES == 1) begin
                  q_clean_n = 1'b1;
                  rise_n    = 1'b1;
                  cnt_n     = '0;
                  state_n   = S_HIGH;
               end else begin
                  cnt_n   = CW'(1);
                  state_n = W_HIGH;
               end
            end
         end
         W_HIGH: begin
            if (!sync_q) begin
               cnt_n   = '0;
               gl_inc  = 1'b1;
               state_n = S_LOW;
            end else if (cnt == CMAX) begin
               q_clean_n = 1'b1;
               rise_n    = 1'b1;
               cnt_n     = '0;
               state_n   = S_HIGH;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_HIGH: begin
            if (!sync_q) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  q_clean_n = 1'b0;
                  fall_n    = 1'b1;
                  cnt_n     = '0;
                  state_n   = S_LOW;
               end else begin
                  cnt_n   = CW'(1);
                  state_n = W_LOW;
               end
            end
         end
         W_LOW: begin
            if (sync_q) begin
               cnt_n   = '0;
               gl_inc  = 1'b1;
               state_n = S_HIGH;
            end else if (cnt == CMAX) begin
               q_clean_n = 1'b0;
               fall_n    = 1'b1;
               cnt_n     = '0;
               state_n   = S_LOW;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: begin
            state_n = S_LOW;
            cnt_n   = '0;
         end
      endcase
   end

endmodule
